instruction_executor: RTL
=========================

Name: instruction_executor

Overview:
- Execute/writeback stage that sits directly downstream of the instruction decoder.
- Consumes the decoded fields (4-bit opcode, 2-bit source register, 2-bit destination register), reads a 4-entry register file, runs a simple ALU or an iterative multiply, and writes back the result.
- Updates the zero and carry flags and reports each writeback on a one-cycle strobe.

Parameters:
- DATA_W, 8, register and ALU data width; multiply iteration count equals DATA_W.
- NUM_REGS, 4, register-file depth; fixed by the 2-bit register fields.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_op_code  in  4  decoded opcode.
- in_src  in  2  source register index.
- in_dst  in  2  destination register index.
- wb_valid  out  1  one-cycle pulse: a register was written.
- wb_dst  out  2  index of the register written.
- wb_data  out  DATA_W  value written.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.
- halted  out  1  HALT was executed.
- dbg_addr  in  2  debug read address.
- dbg_data  out  DATA_W  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (synchronous, active-high; wins over all other activity):
  - All registers, flags, wb_valid, wb_dst, wb_data and halted go to 0; state goes to IDLE.
  - A multiply in progress is aborted with no writeback.
- Handshake:
  - in_ready = (state==IDLE) && !halted.
  - An instruction is accepted on a rising edge where in_valid && in_ready.
  - At accept, opcode, src, dst and both operand values (rs=reg[src], rd=reg[dst]) are captured.
- States:
  - IDLE: accept moves to EXEC, or to MUL for opcode 13.
  - EXEC: one cycle; writes the register and/or flags at the end of the cycle, then returns to IDLE.
  - MUL: shift-add over DATA_W cycles; writes at the end of the last cycle, then returns to IDLE.
  - HALT: terminal; left only by reset.
- Latency:
  - Single-cycle ops: accept at edge k, regfile and flags update at edge k+1, wb_valid high during the cycle after k+1. Throughput is 1 instruction per 2 cycles.
  - MUL: accept at edge k, write at edge k+DATA_W, wb_valid follows that edge.
- Opcodes (res = result written to reg[dst]; all arithmetic modulo 2^DATA_W):
  - 0 NOP: no write, no flag change, no wb_valid.
  - 1 MOV: res=rs.
  - 2 ADD: res=rd+rs; C=carry out.
  - 3 SUB: res=rd-rs; C=borrow (rd<rs).
  - 4 AND, 5 OR, 6 XOR: bitwise rd op rs.
  - 7 NOT: res=~rs.
  - 8 SHL: res=rs<<1; C=rs[MSB].
  - 9 SHR: res=rs>>1 (logical); C=rs[0].
  - 10 INC: res=rd+1; C=carry (rd was all-ones).
  - 11 DEC: res=rd-1; C=borrow (rd was 0).
  - 12 CLR: res=0.
  - 13 MUL: res=low DATA_W bits of rd*rs; C=(high half !=0).
  - 14 CMP: flags as SUB, no write, no wb_valid.
  - 15 HALT: halted=1 at edge k+1; in_ready stays 0 until reset; no write.
- Flags:
  - Z=(res==0) for every writing op and for CMP.
  - C=0 for MOV, AND, OR, XOR, NOT and CLR.
  - NOP and HALT leave both flags unchanged.
- Register aliasing:
  - src==dst is legal; operands are taken from the captured values (e.g. ADD r1,r1 doubles r1).
  - The debug port reflects a write from the edge that performs it onward.
- Input handling:
  - in_valid while in_ready=0 is ignored; upstream must hold the instruction until accepted.
  - Input fields are ignored when not accepted.

Decomposition:
- Shared package exec_pkg:
  - opcode localparams (OP_NOP..OP_HALT);
  - state encoding (IDLE, EXEC, MUL, HALT);
  - DATA_W default.
- Sub-module seq_multiplier:
  - ports: start, a, b → busy, done, product[2*DATA_W-1:0];
  - DATA_W-cycle shift-add.
- Register file and the single-cycle ALU stay inline.

Test Plan:
- Reset, then INC r0 ×3, then MOV r1←r0 → r0=3, r1=3 via dbg; wb_valid pulses 4 times; each pulse comes 2 cycles after its accept; flag_z=0.
- r0=3, r1=3: SUB r0←r0-r1 → r0=0, Z=1, C=0. Then DEC r0 → r0=0xFF, C=1, Z=0. Then ADD r0←r0+r1 → r0=0x02, C=1.
- r2=0x10 (INC ×16), r3=0x11: MUL r2←r2*r3 → in_ready low for 8 cycles, r2=0x10, C=1 (product 0x110). Then MUL with r2=3, r3=5 → 15, C=0.
- CMP r0=5 vs r1=5 → Z=1, C=0, no wb_valid, r0 unchanged. NOP → no wb_valid, flags unchanged.
- HALT → halted=1 one cycle after accept, in_ready=0. Further INC with in_valid=1 → no register change. rst → halted=0, in_ready=1, all registers 0.
- Assert rst 3 cycles into a MUL → no wb_valid, destination register = 0, state IDLE; next instruction accepted normally.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute/writeback stage.
//   - default data width and register-file depth
//   - opcode encodings OP_NOP .. OP_HALT
//   - FSM state encoding
//   - opcode classification helpers used by the writeback logic
package exec_pkg;

  localparam int EXEC_DATA_W   = 8;
  localparam int EXEC_NUM_REGS = 4;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_INC  = 4'd10;
  localparam logic [3:0] OP_DEC  = 4'd11;
  localparam logic [3:0] OP_CLR  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_CMP  = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_HALT = 2'd3
  } exec_state_t;

  // True for opcodes that write a register and pulse wb_valid.
  function automatic logic op_writes_reg(input logic [3:0] op);
    return (op != OP_NOP) && (op != OP_CMP) && (op != OP_HALT);
  endfunction

  // True for opcodes that update Z and C (every op except NOP and HALT).
  function automatic logic op_updates_flags(input logic [3:0] op);
    return (op != OP_NOP) && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, DATA_W cycles from start to done.
//   clk, rst     : clock, synchronous active-high reset (aborts any run)
//   start        : load a/b and begin; bit 0 of b is consumed on this edge
//   a, b         : unsigned operands (multiplicand, multiplier)
//   busy         : a multiplication is in flight
//   done         : product valid this cycle; the run ends on the next edge
//   product      : full 2*DATA_W result
module seq_multiplier #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  logic [2*DATA_W-1:0] acc_r;
  logic [2*DATA_W-1:0] mcand_r;
  logic [DATA_W-1:0]   mplier_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                busy_r;

  // Shift-add datapath: the start edge does the first partial product so
  // the last one lands DATA_W-1 edges later and done is high in the cycle
  // before the DATA_W-th edge, letting the consumer write on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r    <= {(2*DATA_W){1'b0}};
      mcand_r  <= {(2*DATA_W){1'b0}};
      mplier_r <= {DATA_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
    end else if (start) begin
      acc_r    <= b[0] ? {{DATA_W{1'b0}}, a} : {(2*DATA_W){1'b0}};
      mcand_r  <= {{(DATA_W-1){1'b0}}, a, 1'b0};
      mplier_r <= {1'b0, b[DATA_W-1:1]};
      cnt_r    <= CNT_ONE;
      busy_r   <= 1'b1;
    end else if (busy_r) begin
      if (cnt_r == CNT_LAST) begin
        busy_r <= 1'b0;
      end else begin
        acc_r    <= acc_r + (mplier_r[0] ? mcand_r : {(2*DATA_W){1'b0}});
        mcand_r  <= {mcand_r[2*DATA_W-2:0], 1'b0};
        mplier_r <= {1'b0, mplier_r[DATA_W-1:1]};
        cnt_r    <= cnt_r + CNT_ONE;
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

  assign busy    = busy_r;
  assign done    = busy_r && (cnt_r == CNT_LAST);
  assign product = acc_r;

endmodule

// File: rtl/instruction_executor.sv
// Execute/writeback stage fed by the instruction decoder.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : decoded-instruction handshake
//   in_op_code/src/dst  : decoded opcode and register indices
//   wb_valid/dst/data   : one-cycle writeback report
//   flag_z, flag_c      : zero and carry/borrow flags
//   halted              : HALT executed; only reset clears it
//   dbg_addr/dbg_data   : combinational register-file read port
module instruction_executor
  import exec_pkg::*;
#(
  parameter int DATA_W   = EXEC_DATA_W,
  parameter int NUM_REGS = EXEC_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op_code,
  input  logic [1:0]        in_src,
  input  logic [1:0]        in_dst,
  output logic              wb_valid,
  output logic [1:0]        wb_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  exec_state_t state_r, state_nxt_s;

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [3:0]        op_r;
  logic [1:0]        dst_r;
  logic [DATA_W-1:0] rs_r, rd_r;

  logic              accept_s;
  logic              mul_start_s;
  logic              mul_busy_s;
  logic              mul_done_s;
  logic [2*DATA_W-1:0] mul_prod_s;

  logic [DATA_W:0]   sum_s, diff_s, inc_s, dec_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              alu_c_s;

  assign in_ready    = (state_r == ST_IDLE) && !halted && !mul_busy_s;
  assign accept_s    = in_valid && in_ready;
  assign mul_start_s = accept_s && (in_op_code == OP_MUL);
  assign dbg_data    = regs_r[dbg_addr];

  // Operands come straight from the register file at accept time, so the
  // multiplier sees the same values that are captured into rs_r/rd_r.
  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_s),
    .a       (regs_r[in_dst]),
    .b       (regs_r[in_src]),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (in_op_code == OP_MUL) begin
            state_nxt_s = ST_MUL;
          end else begin
            state_nxt_s = ST_EXEC;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (op_r == OP_HALT) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Single-cycle ALU on the captured operands. The extra top bit of the
  // widened sums/differences is the carry or borrow.
  always_comb begin
    sum_s     = {1'b0, rd_r} + {1'b0, rs_r};
    diff_s    = {1'b0, rd_r} - {1'b0, rs_r};
    inc_s     = {1'b0, rd_r} + {{DATA_W{1'b0}}, 1'b1};
    dec_s     = {1'b0, rd_r} - {{DATA_W{1'b0}}, 1'b1};
    alu_res_s = {DATA_W{1'b0}};
    alu_c_s   = 1'b0;
    case (op_r)
      OP_MOV: alu_res_s = rs_r;
      OP_ADD: begin
        alu_res_s = sum_s[DATA_W-1:0];
        alu_c_s   = sum_s[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        alu_res_s = diff_s[DATA_W-1:0];
        alu_c_s   = diff_s[DATA_W];
      end
      OP_AND: alu_res_s = rd_r & rs_r;
      OP_OR:  alu_res_s = rd_r | rs_r;
      OP_XOR: alu_res_s = rd_r ^ rs_r;
      OP_NOT: alu_res_s = ~rs_r;
      OP_SHL: begin
        alu_res_s = {rs_r[DATA_W-2:0], 1'b0};
        alu_c_s   = rs_r[DATA_W-1];
      end
      OP_SHR: begin
        alu_res_s = {1'b0, rs_r[DATA_W-1:1]};
        alu_c_s   = rs_r[0];
      end
      OP_INC: begin
        alu_res_s = inc_s[DATA_W-1:0];
        alu_c_s   = inc_s[DATA_W];
      end
      OP_DEC: begin
        alu_res_s = dec_s[DATA_W-1:0];
        alu_c_s   = dec_s[DATA_W];
      end
      default: begin
        alu_res_s = {DATA_W{1'b0}};
        alu_c_s   = 1'b0;
      end
    endcase
  end

  // Instruction capture, register file, flags and writeback report.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      op_r     <= OP_NOP;
      dst_r    <= 2'd0;
      rs_r     <= {DATA_W{1'b0}};
      rd_r     <= {DATA_W{1'b0}};
      wb_valid <= 1'b0;
      wb_dst   <= 2'd0;
      wb_data  <= {DATA_W{1'b0}};
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept_s) begin
        op_r  <= in_op_code;
        dst_r <= in_dst;
        rs_r  <= regs_r[in_src];
        rd_r  <= regs_r[in_dst];
      end
      if (state_r == ST_EXEC) begin
        if (op_writes_reg(op_r)) begin
          regs_r[dst_r] <= alu_res_s;
          wb_valid      <= 1'b1;
          wb_dst        <= dst_r;
          wb_data       <= alu_res_s;
        end
        if (op_updates_flags(op_r)) begin
          flag_z <= (alu_res_s == {DATA_W{1'b0}});
          flag_c <= alu_c_s;
        end
        if (op_r == OP_HALT) begin
          halted <= 1'b1;
        end
      end else if ((state_r == ST_MUL) && mul_done_s) begin
        regs_r[dst_r] <= mul_prod_s[DATA_W-1:0];
        wb_valid      <= 1'b1;
        wb_dst        <= dst_r;
        wb_data       <= mul_prod_s[DATA_W-1:0];
        flag_z        <= (mul_prod_s[DATA_W-1:0] == {DATA_W{1'b0}});
        flag_c        <= (mul_prod_s[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}});
      end
    end
  end

endmodule
